// File: rtl/uart_cmd_responder.sv
// UART command responder: receives 5-byte request packets
// (A5 CMD ADDR DATA CSUM), executes register writes/reads and
// answers with a 3-byte response (5A STATUS RDATA).
//
// state   | meaning
// --------+------------------------------------------------------
// HUNT    | waiting for the 0xA5 sync byte, other bytes discarded
// RCV     | collecting CMD/ADDR/DATA/CSUM, inter-byte timeout armed
// EXEC    | checks packet, commits write, latches response bytes
// TX_LOAD | tx_start pulse with the current response byte
// TX_WAIT | holding tx_data until the transmitter reports tx_done
module uart_cmd_responder #(
    parameter int NUM_REGS    = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] err_count
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [8:0]    NREGS_9  = 9'(NUM_REGS);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        HUNT,
        RCV,
        EXEC,
        TX_LOAD,
        TX_WAIT
    } state_t;

    state_t        state;
    logic [1:0]    byte_idx;
    logic [1:0]    tx_idx;
    logic [TW-1:0] timer;
    logic [7:0]    pkt_cmd;
    logic [7:0]    pkt_addr;
    logic [7:0]    pkt_data;
    logic [7:0]    pkt_csum;
    logic [7:0]    resp_status;
    logic [7:0]    resp_data;
    logic [7:0]    regs [NUM_REGS];

    logic [7:0]    exec_status;
    logic [7:0]    exec_rdata;

    // Packet checks in priority order and the response data byte.
    always_comb begin
        exec_status = 8'h00;
        exec_rdata  = 8'h00;
        if (pkt_csum != (pkt_cmd ^ pkt_addr ^ pkt_data)) begin
            exec_status = 8'h01;
        end else if (pkt_cmd != 8'h01 && pkt_cmd != 8'h02) begin
            exec_status = 8'h02;
        end else if ({1'b0, pkt_addr} >= NREGS_9) begin
            exec_status = 8'h03;
        end
        if (exec_status == 8'h00) begin
            if (pkt_cmd == 8'h02) begin
                exec_rdata = regs[pkt_addr[AW-1:0]];
            end else begin
                exec_rdata = pkt_data;
            end
        end
    end

    // Sequencer: receive, execute, transmit; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            byte_idx    <= 2'd0;
            tx_idx      <= 2'd0;
            timer       <= '0;
            pkt_cmd     <= 8'h00;
            pkt_addr    <= 8'h00;
            pkt_data    <= 8'h00;
            pkt_csum    <= 8'h00;
            resp_status <= 8'h00;
            resp_data   <= 8'h00;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            wr_strobe   <= 1'b0;
            wr_addr     <= 8'h00;
            wr_data     <= 8'h00;
            err_count   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            tx_start  <= 1'b0;
            wr_strobe <= 1'b0;
            case (state)
                HUNT: begin
                    if (rx_done && rx_data == 8'hA5) begin
                        state    <= RCV;
                        byte_idx <= 2'd0;
                        timer    <= TMR_LOAD;
                    end
                end
                RCV: begin
                    if (rx_done) begin
                        case (byte_idx)
                            2'd0:    pkt_cmd  <= rx_data;
                            2'd1:    pkt_addr <= rx_data;
                            2'd2:    pkt_data <= rx_data;
                            default: pkt_csum <= rx_data;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                        timer    <= TMR_LOAD;
                        if (byte_idx == 2'd3) begin
                            state <= EXEC;
                        end
                    end else if (timer == '0) begin
                        state <= HUNT;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                EXEC: begin
                    resp_status <= exec_status;
                    resp_data   <= exec_rdata;
                    if (exec_status != 8'h00) begin
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else if (pkt_cmd == 8'h01) begin
                        regs[pkt_addr[AW-1:0]] <= pkt_data;
                        wr_strobe <= 1'b1;
                        wr_addr   <= pkt_addr;
                        wr_data   <= pkt_data;
                    end
                    tx_idx   <= 2'd0;
                    tx_data  <= 8'h5A;
                    tx_start <= 1'b1;
                    state    <= TX_LOAD;
                end
                TX_LOAD: begin
                    state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done) begin
                        if (tx_idx == 2'd2) begin
                            state <= HUNT;
                        end else begin
                            tx_idx   <= tx_idx + 2'd1;
                            tx_data  <= (tx_idx == 2'd0) ? resp_status : resp_data;
                            tx_start <= 1'b1;
                            state    <= TX_LOAD;
                        end
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: directed table vectors,
// hand-written corner sequences and randomized packets against a
// packet-level reference model.
module tb_uart_cmd_responder;

    localparam int NUM_REGS    = 8;
    localparam int TIMEOUT_CYC = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] err_count;

    uart_cmd_responder #(.NUM_REGS(NUM_REGS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // transmitter agent / monitors
    logic [7:0]  tx_q[$];
    logic [15:0] wr_q[$];
    int          tx_delay  = 2;
    bit          agent_busy = 1'b0;
    bit          no_stab   = 1'b0;
    int          unstable  = 0;
    int          dbl_start = 0;
    bit          prev_ts   = 1'b0;

    // reference model state
    logic [7:0] mem [0:255];
    int         err_m;

    typedef struct {
        logic [7:0] cmd, addr, data, csum;
        logic [7:0] st, rd;
        bit         wr;
        logic [7:0] err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        err_m = 0;
    endfunction

    function automatic void model_pkt(input logic [7:0] c, a, d, s,
                                      output logic [7:0] st, output logic [7:0] rd,
                                      output bit wr);
        wr = 1'b0;
        rd = 8'h00;
        if ((c ^ a ^ d) != s)         st = 8'h01;
        else if (c != 1 && c != 2)    st = 8'h02;
        else if (int'(a) >= NUM_REGS) st = 8'h03;
        else                          st = 8'h00;
        if (st != 0) begin
            if (err_m < 255) err_m++;
        end else if (c == 8'h01) begin
            mem[a] = d;
            rd = d;
            wr = 1'b1;
        end else begin
            rd = mem[a];
        end
    endfunction

    // Transmitter: record each byte, check it is held, answer with tx_done.
    initial begin
        logic [7:0] held;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                agent_busy = 1'b1;
                held = tx_data;
                tx_q.push_back(tx_data);
                repeat (tx_delay) begin
                    @(negedge clk);
                    if (tx_data !== held && !reset && !no_stab) unstable++;
                end
                @(posedge clk); #1 tx_done = 1'b1;
                @(posedge clk); #1 tx_done = 1'b0;
                agent_busy = 1'b0;
            end
        end
    end

    // Monitor pulse widths and committed writes.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && prev_ts) dbl_start++;
            prev_ts = tx_start;
            if (wr_strobe === 1'b1) wr_q.push_back({wr_addr, wr_data});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic run_packet(input logic [7:0] c, a, d, s, input int gap, input bit inject);
        int lat;
        int cyc;
        tx_q.delete();
        wr_q.delete();
        send_byte(8'hA5, gap);
        send_byte(c, gap);
        send_byte(a, gap);
        send_byte(d, gap);
        rx_data = s;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        lat = 0;
        while (!tx_start && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 2);
        if (inject) begin
            @(posedge clk); #1;
            rx_data = 8'hA5;
            rx_done = 1'b1;
            @(posedge clk); #1;
            rx_done = 1'b0;
        end
        cyc = 0;
        while ((tx_q.size() < 3 || agent_busy) && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 200) check("resp_timeout", tx_q.size(), 3);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_resp(input string tag, input logic [7:0] st, rd, input bit wr,
                              input logic [7:0] a, d);
        check({tag, "_nbytes"}, tx_q.size(), 3);
        check({tag, "_hdr"},    (tx_q.size() > 0) ? tx_q[0] : 8'hEE, 8'h5A);
        check({tag, "_status"}, (tx_q.size() > 1) ? tx_q[1] : 8'hEE, st);
        check({tag, "_rdata"},  (tx_q.size() > 2) ? tx_q[2] : 8'hEE, rd);
        check({tag, "_wrcnt"},  wr_q.size(), int'(wr));
        if (wr && wr_q.size() > 0) check({tag, "_wrbus"}, wr_q[0], {a, d});
    endtask

    initial begin
        vec_t       tbl[10];
        logic [7:0] st, rd;
        bit         wr;
        logic [7:0] c, a, d, s, b;
        int         cyc;

        tbl[0] = '{8'h01, 8'h03, 8'h7E, 8'h7C, 8'h00, 8'h7E, 1'b1, 8'd0};
        tbl[1] = '{8'h02, 8'h03, 8'h00, 8'h01, 8'h00, 8'h7E, 1'b0, 8'd0};
        tbl[2] = '{8'h01, 8'h03, 8'h7E, 8'h00, 8'h01, 8'h00, 1'b0, 8'd1};
        tbl[3] = '{8'h01, 8'h09, 8'h11, 8'h19, 8'h03, 8'h00, 1'b0, 8'd2};
        tbl[4] = '{8'h02, 8'h03, 8'h00, 8'h01, 8'h00, 8'h7E, 1'b0, 8'd2};
        tbl[5] = '{8'h03, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00, 1'b0, 8'd3};
        tbl[6] = '{8'h01, 8'h07, 8'hC3, 8'hC5, 8'h00, 8'hC3, 1'b1, 8'd3};
        tbl[7] = '{8'h02, 8'h08, 8'h00, 8'h0A, 8'h03, 8'h00, 1'b0, 8'd4};
        tbl[8] = '{8'h02, 8'h07, 8'hFF, 8'hFA, 8'h00, 8'hC3, 1'b0, 8'd4};
        tbl[9] = '{8'h05, 8'h20, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0, 8'd5};

        reset   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_start",  tx_start,  0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_tx_data",   tx_data,   0);
        check("rst_err_count", err_count, 0);
        check("rst_wr_addr",   wr_addr,   0);
        check("rst_wr_data",   wr_data,   0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // directed table
        for (int i = 0; i < 10; i++) begin
            run_packet(tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].csum, 0, 1'b0);
            model_pkt(tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].csum, st, rd, wr);
            check_resp($sformatf("tbl%0d", i), tbl[i].st, tbl[i].rd, tbl[i].wr,
                       tbl[i].addr, tbl[i].data);
            check($sformatf("tbl%0d_err", i), err_count, tbl[i].err);
        end
        check("unstable_tbl", unstable, 0);

        // leading garbage is discarded without counting an error
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        run_packet(8'h02, 8'h00, 8'h00, 8'h02, 0, 1'b0);
        model_pkt(8'h02, 8'h00, 8'h00, 8'h02, st, rd, wr);
        check_resp("garbage", 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        check("garbage_err", err_count, err_m);

        // inter-byte gap just under the timeout is still accepted
        run_packet(8'h01, 8'h05, 8'h3C, 8'h38, TIMEOUT_CYC - 2, 1'b0);
        model_pkt(8'h01, 8'h05, 8'h3C, 8'h38, st, rd, wr);
        check_resp("slow", 8'h00, 8'h3C, 1'b1, 8'h05, 8'h3C);

        // full timeout gap aborts the packet silently
        tx_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h01, TIMEOUT_CYC);
        repeat (5) begin @(posedge clk); #1; end
        err_m++;
        check("timeout_tx", tx_q.size(), 0);
        check("timeout_err", err_count, err_m);
        run_packet(8'h02, 8'h05, 8'h00, 8'h07, 0, 1'b0);
        model_pkt(8'h02, 8'h05, 8'h00, 8'h07, st, rd, wr);
        check_resp("after_to", 8'h00, 8'h3C, 1'b0, 8'h00, 8'h00);

        // rx_done during the response is dropped
        tx_delay = 4;
        run_packet(8'h02, 8'h07, 8'h00, 8'h05, 0, 1'b1);
        model_pkt(8'h02, 8'h07, 8'h00, 8'h05, st, rd, wr);
        check_resp("inject", 8'h00, 8'hC3, 1'b0, 8'h00, 8'h00);
        run_packet(8'h02, 8'h03, 8'h00, 8'h01, 0, 1'b0);
        model_pkt(8'h02, 8'h03, 8'h00, 8'h01, st, rd, wr);
        check_resp("post_inject", 8'h00, 8'h7E, 1'b0, 8'h00, 8'h00);

        // reset after the second tx_start aborts the response
        tx_delay = 2;
        no_stab  = 1'b1;
        tx_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        cyc = 0;
        while (tx_q.size() < 2 && cyc < 100) begin @(posedge clk); cyc++; end
        #1;
        check("abort_reach2", tx_q.size(), 2);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (20) begin @(posedge clk); #1; end
        check("abort_tx_cnt", tx_q.size(), 2);
        check("abort_err",    err_count, 0);
        check("abort_tx_data", tx_data, 0);
        no_stab = 1'b0;
        run_packet(8'h02, 8'h03, 8'h00, 8'h01, 0, 1'b0);
        model_pkt(8'h02, 8'h03, 8'h00, 8'h01, st, rd, wr);
        check_resp("regs_cleared", 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);

        // randomized packets against the reference model
        for (int n = 0; n < 80; n++) begin
            int pre;
            pre = $urandom_range(0, 2);
            for (int k = 0; k < pre; k++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                send_byte(b, $urandom_range(0, 2));
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c = 8'h01;
                4, 5, 6, 7: c = 8'h02;
                default:    c = 8'($urandom);
            endcase
            a = 8'($urandom_range(0, 11));
            d = 8'($urandom);
            s = c ^ a ^ d;
            if ($urandom_range(0, 6) == 0) s = s ^ (8'h01 << $urandom_range(0, 7));
            tx_delay = $urandom_range(0, 5);
            run_packet(c, a, d, s, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
            model_pkt(c, a, d, s, st, rd, wr);
            check_resp($sformatf("rnd%0d", n), st, rd, wr, a, d);
            check($sformatf("rnd%0d_err", n), err_count, err_m);
        end

        check("tx_data_stable", unstable, 0);
        check("tx_start_width", dbl_start, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, giving the number of 8-bit internal registers (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000, giving the maximum clk cycles allowed between packet bytes.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rx_done, input, 1 bit: one-cycle pulse from the receiver when rx_data is valid.
REQ-006 SHALL have port rx_data, input, 8 bits: received byte, sampled only when rx_done=1.
REQ-007 SHALL have port tx_start, output, 1 bit: one-cycle pulse requesting the transmitter to send tx_data.
REQ-008 SHALL have port tx_data, output, 8 bits: byte to transmit.
REQ-009 SHALL have port tx_done, input, 1 bit: one-cycle pulse from the transmitter when a byte has finished.
REQ-010 SHALL have port wr_strobe, output, 1 bit: one-cycle pulse when a register write commits.
REQ-011 SHALL have port wr_addr, output, 8 bits: address of the last committed write.
REQ-012 SHALL have port wr_data, output, 8 bits: data of the last committed write.
REQ-013 SHALL have port err_count, output, 8 bits: count of rejected packets, saturating at 0xFF.

Function
REQ-014 SHALL accept request packets of exactly 5 bytes: SYNC=0xA5, CMD, ADDR, DATA, CSUM, where CSUM = CMD^ADDR^DATA.
REQ-015 SHALL treat CMD 0x01 as a write and CMD 0x02 as a read; for a read, DATA is don't-care but is still included in CSUM.
REQ-016 SHALL use the states HUNT, RCV, EXEC, TX_LOAD, TX_WAIT, with a 2-bit byte index in RCV and in the TX states.
REQ-017 HUNT: on rx_done with rx_data==0xA5, SHALL go to RCV with index 0; any other byte SHALL be discarded without changing err_count.
REQ-018 RCV: each rx_done SHALL store the byte and increment the index; after the CSUM byte the block SHALL go to EXEC on the next cycle.
REQ-019 RCV: the timeout counter SHALL clear on every accepted byte; if it reaches TIMEOUT_CYC, the block SHALL go to HUNT, increment err_count, and send no response.
REQ-020 EXEC: status SHALL be determined by the first failing check, in this order:
- bad checksum -> 0x01
- CMD not 0x01/0x02 -> 0x02
- ADDR >= NUM_REGS -> 0x03
- otherwise 0x00
REQ-021 EXEC with status 0x00 and a write SHALL update reg[ADDR]; in the same cycle it SHALL pulse wr_strobe for one cycle and load wr_addr/wr_data.
REQ-022 EXEC: the response data byte SHALL be reg[ADDR] for a read, the written DATA for a write, and 0x00 when status != 0.
REQ-023 EXEC with status != 0 SHALL increment err_count, saturating, and SHALL NOT modify any register.
REQ-024 SHALL respond with 3 bytes in order: 0x5A, STATUS, RDATA.
REQ-025 TX_LOAD SHALL drive tx_data and pulse tx_start for exactly one cycle, then go to TX_WAIT.
REQ-026 tx_data SHALL remain stable from the tx_start pulse until tx_done.
REQ-027 TX_WAIT: on tx_done, the block SHALL go to TX_LOAD for the next byte, or to HUNT after the third byte; TX_WAIT has no timeout.
REQ-028 rx_done asserted in EXEC, TX_LOAD or TX_WAIT SHALL be ignored, so the byte is dropped.
REQ-029 rx_done and tx_done asserted in the same cycle SHALL result in only tx_done being acted upon.
REQ-030 tx_done outside TX_WAIT SHALL be ignored.
REQ-031 Request-end to first tx_start SHALL be 2 cycles: the CSUM rx_done cycle -> EXEC -> TX_LOAD, with tx_start asserted in the TX_LOAD cycle.

Reset
REQ-032 While reset=1, the block SHALL:
- enter HUNT
- clear all registers, err_count, wr_addr, wr_data and the timeout counter
- drive tx_start=0, wr_strobe=0, tx_data=0x00
REQ-033 Reset asserted mid-packet or mid-response SHALL abort it immediately, and no further tx_start SHALL be issued for that packet.

Verification
REQ-034 Write: A5 01 03 7E 7C -> wr_strobe pulses once with wr_addr=03, wr_data=7E; response 5A 00 7E.
REQ-035 Read after write: A5 02 03 00 01 -> response 5A 00 7E; no wr_strobe.
REQ-036 Errors:
- A5 01 03 7E 00 -> 5A 01 00, err_count=1
- A5 01 09 11 19 -> 5A 03 00, err_count=2
- reg[3] unchanged by both
REQ-037 Garbage bytes 00 FF A5 02 00 00 02 -> leading 00 FF discarded; response 5A 00 00.
REQ-038 A5 01 then a TIMEOUT_CYC-cycle gap -> back to HUNT, err_count increments, no tx_start; a following valid packet is answered normally.
REQ-039 Response abort: assert reset after the second tx_start -> tx_start stays 0 and err_count=0; inject rx_done during TX_WAIT -> byte ignored and response completes.
